// File: rtl/decoder_scan_if.sv
// Bus bundle for decoder_scan: control/select inputs plus decoded outputs.
// The master side drives the controls, the slave side (decoder_scan) drives the results.
interface decoder_scan_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
);
    localparam int OUT_W = 2**SEL_W;

    logic               enable;
    logic               mode;
    logic [SEL_W-1:0]   in;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   index;
    logic               wrap;

    modport master (
        output enable, mode, in, load, dwell,
        input  out, index, wrap
    );

    modport slave (
        input  enable, mode, in, load, dwell,
        output out, index, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: one-hot line decoder with direct select and auto-scan modes.
// Optional build macro DECODER_SCAN_ACTIVE_LOW_EN inverts the decoded output
// (all-ones when idle, selected bit low when active); index and wrap are unaffected.
//
// state  | meaning
// IDLE   | disabled, out deasserted, index retained, dwell counter cleared
// DIRECT | out decodes index, index changes only on load
// SCAN   | index auto-advances every dwell+1 cycles, wrap pulses on 7->0 style rollover
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_scan_if.slave bus
);
    localparam int OUT_W = 2**SEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   index_q, index_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               wrap_q, wrap_d;
    logic [OUT_W-1:0]   onehot;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index, dwell counter and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            index_q <= index_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state, next index/counter; load wins over a scan advance.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            state_d = bus.mode ? SCAN : DIRECT;
            if (bus.load) begin
                index_d = bus.in;
                cnt_d   = '0;
            end else if (bus.mode) begin
                if (state_q != SCAN) begin
                    // fresh entry into scan keeps the index and restarts the dwell
                    cnt_d = '0;
                end else if (cnt_q >= bus.dwell) begin
                    // >= so that lowering dwell below the running count advances at once
                    cnt_d   = '0;
                    index_d = index_q + SEL_W'(1);
                    wrap_d  = &index_q;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        onehot = '0;
        if (state_q != IDLE) begin
            onehot[index_q] = 1'b1;
        end
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        bus.out = ~onehot;
`else
        bus.out = onehot;
`endif
        bus.index = index_q;
        bus.wrap  = wrap_q;
    end
endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed scenarios plus random stimulus
// against a behavioural model (active flag, scan flag, index and dwell age as ints).
module tb_decoder_scan;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 4;
    localparam int OUT_W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

    decoder_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model
    bit m_act;    // decoder enabled
    bit m_scan;   // scanning
    int m_idx;    // selected line
    int m_age;    // cycles the current line has already dwelled in scan
    bit m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [OUT_W-1:0] exp_out();
        logic [OUT_W-1:0] o;
        o = m_act ? OUT_W'(1 << m_idx) : '0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        o = ~o;
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_act = 0; m_scan = 0; m_idx = 0; m_age = 0; m_wrap = 0;
    endtask

    // One rising edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        bit was_scanning;
        was_scanning = m_act && m_scan;
        m_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!bus.enable) begin
            m_act = 0;
            m_age = 0;
        end else begin
            m_act  = 1;
            m_scan = bus.mode;
            if (bus.load) begin
                m_idx = int'(bus.in);
                m_age = 0;
            end else if (!bus.mode || !was_scanning) begin
                m_age = 0;
            end else if (m_age >= int'(bus.dwell)) begin
                m_wrap = (m_idx == OUT_W - 1);
                m_idx  = (m_idx + 1) % OUT_W;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic drive(input bit en, input bit md, input bit ld,
                         input int sel, input int dw);
        bus.enable = en;
        bus.mode   = md;
        bus.load   = ld;
        bus.in     = SEL_W'(sel);
        bus.dwell  = DWELL_W'(dw);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".out"},   32'(bus.out),   32'(exp_out()));
        check({tag, ".index"}, 32'(bus.index), 32'(m_idx));
        check({tag, ".wrap"},  32'(bus.wrap),  32'(m_wrap));
    endtask

    initial begin
        int prev;
        model_reset();
        drive(1, 0, 0, 0, 0);

        // reset state while rst_n low
        #3;
        check("rst.out",   32'(bus.out),   32'(exp_out()));
        check("rst.index", 32'(bus.index), 0);
        check("rst.wrap",  32'(bus.wrap),  0);
        #9 rst_n = 1'b1;

        // direct decode of every select value
        for (int i = 0; i < OUT_W; i++) begin
            drive(1, 0, 1, i, 0);
            step("direct");
        end
        drive(1, 0, 0, 3, 0);
        step("direct_hold");
        drive(0, 0, 0, 1, 0);
        step("disable");
        drive(0, 0, 1, 2, 0);
        step("load_ignored");

        // scan with dwell 0 starting from index 6
        drive(1, 0, 1, 6, 0);
        step("scan0_load6");
        drive(1, 1, 0, 0, 0);
        repeat (20) step("scan0");

        // scan with dwell 2
        drive(1, 1, 0, 0, 2);
        repeat (12) step("scan2");
        for (int k = 0; k < 10 && m_age != 2; k++) step("scan2_seek");
        check("scan2_age_reached", 32'(m_age), 2);
        drive(1, 1, 0, 0, 0);
        prev = int'(bus.index);
        step("scan2_to0");
        check("scan2_to0_adv", 32'(bus.index), 32'((prev + 1) % OUT_W));

        // dwell lowered below the running count
        drive(1, 1, 0, 0, 7);
        for (int k = 0; k < 20 && m_age != 4; k++) step("dwell7_seek");
        check("dwell7_age_reached", 32'(m_age), 4);
        drive(1, 1, 0, 0, 1);
        prev = int'(bus.index);
        step("dwell_lower");
        check("dwell_lower_adv", 32'(bus.index), 32'((prev + 1) % OUT_W));

        // load during scan takes priority over advance
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 20 && bus.index != 5; k++) step("seek5");
        check("reach5", 32'(bus.index), 5);
        drive(1, 1, 1, 2, 0);
        step("scan_load2");
        check("scan_load2_idx", 32'(bus.index), 2);
        drive(1, 1, 0, 0, 0);
        for (int k = 0; k < 20 && bus.index != 7; k++) step("seek7");
        check("reach7", 32'(bus.index), 7);
        drive(1, 1, 1, 0, 0);
        step("scan_load0");
        check("scan_load0_nowrap", 32'(bus.wrap), 0);

        // load coincident with DIRECT -> SCAN
        drive(1, 0, 0, 0, 0);
        step("pre_modechg");
        drive(1, 1, 1, 3, 0);
        step("modechg_load");
        drive(1, 1, 0, 0, 0);
        repeat (3) step("modechg_scan");

        // asynchronous reset mid-scan
        drive(1, 1, 0, 0, 1);
        repeat (5) step("pre_reset");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.out",   32'(bus.out),   32'(exp_out()));
        check("midrst.index", 32'(bus.index), 0);
        check("midrst.wrap",  32'(bus.wrap),  0);
        repeat (2) step("in_reset");
        #3 rst_n = 1'b1;
        repeat (6) step("post_reset");

        // random stimulus
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 8) != 0,
                  ($urandom % 4) != 0 ? bus.mode : bit'($urandom % 2),
                  ($urandom % 7) == 0,
                  int'($urandom % OUT_W),
                  ($urandom % 10) == 0 ? int'($urandom % 6) : int'(bus.dwell));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3, select width; output width OUT_W = 2**SEL_W is derived, not overridable.
REQ-002 Parameter DWELL_W, default 4, width of scan dwell setting.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  1 = decoder active; 0 = outputs deasserted.
REQ-006 mode  input  1  0 = direct (decode captured select), 1 = scan (auto-advance select).
REQ-007 in  input  SEL_W  select value captured on load.
REQ-008 load  input  1  capture in into index this cycle.
REQ-009 dwell  input  DWELL_W  cycles-per-step minus one in scan mode.
REQ-010 out  output  OUT_W  one-hot decode of index while active.
REQ-011 index  output  SEL_W  currently selected line (registered).
REQ-012 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-013 States: IDLE, DIRECT, SCAN, one state register.
REQ-014 Transitions evaluated every edge: enable=0 -> IDLE; enable=1 & mode=0 -> DIRECT; enable=1 & mode=1 -> SCAN.
REQ-015 out = one-hot(index) when state is DIRECT or SCAN, all-zeros in IDLE; derived only from registered state/index, so out reflects inputs one cycle after they are sampled.
REQ-016 load sampled only when enable=1; index <= in at that edge, dwell counter <= 0; load while enable=0 ignored.
REQ-017 DIRECT: index changes only via load; dwell counter held at 0.
REQ-018 SCAN: dwell counter increments each cycle; when counter >= dwell, counter <= 0 and index <= index+1 modulo OUT_W.
REQ-019 dwell=0 -> index advances every cycle; dwell=D -> each index held D+1 cycles.
REQ-020 dwell lowered mid-count below current counter -> advance at next edge (>= comparison), no stall.
REQ-021 Entering SCAN from IDLE or DIRECT: index retained, counter starts at 0.
REQ-022 Entering IDLE: index retained, counter cleared.
REQ-023 wrap = 1 for exactly the first cycle index reads 0 after a scan advance from OUT_W-1; 0 otherwise.
REQ-024 load in SCAN takes priority over advance in the same cycle; load to 0 never asserts wrap.
REQ-025 load coincident with mode change DIRECT->SCAN: index <= in, state SCAN, counter 0.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, index 0, counter 0, out all-zeros, wrap 0, independent of clk.
REQ-027 Reset asserted mid-scan discards progress; after rst_n release first active cycle starts at index 0.
REQ-028 Reset deassertion takes effect at the first rising clk edge after rst_n high.

Configuration
REQ-029 Macro DECODER_SCAN_ACTIVE_LOW_EN defined: out is bitwise inverted -- all-ones in IDLE/reset, selected bit 0 while active.
REQ-030 Macro undefined: out active-high per REQ-015; index and wrap identical in both builds.

Verification (SEL_W=3, DWELL_W=4)
REQ-031 Reset: rst_n=0 mid-clock with enable=1 -> out=00000000, index=0, wrap=0 immediately, before next edge.
REQ-032 Direct: enable=1, mode=0, load=1 with in=0..7 in turn -> one cycle later out=00000001,00000010,...,10000000; enable=0 -> out=00000000 next cycle, index held.
REQ-033 Scan dwell=0: enable=1, mode=1 from index 6 -> index 7,0,1...; wrap high only in the cycle index=0; 8-cycle period thereafter.
REQ-034 Scan dwell=2: each index held 3 cycles; dwell changed to 0 while counter=2 -> advance on next edge.
REQ-035 Load during scan: index=5, load=1 in=2 at advance edge -> index=2, counter 0, wrap=0; load in=0 from index 7 -> wrap stays 0.
REQ-036 Build with DECODER_SCAN_ACTIVE_LOW_EN: repeat REQ-032 -> out=11111110..01111111 active, 11111111 idle/reset.
